// File: rtl/button_scanner_pkg.sv
// Shared types and helpers for the button scanner slice:
// scan FSM states, the queued event record and an index-width helper.
package button_scanner_pkg;

    // Widest channel index the event record can carry (up to 16 channels).
    localparam int MAX_ID_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // One queued press/release event.
    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic                press;
    } button_event_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_scanner_if.sv
// Event handshake bundle between the scanner (master) and the control FSM (slave).
interface button_scanner_if #(
    parameter int ID_W = 2
);
    logic            event_valid;
    logic            event_ready;
    logic [ID_W-1:0] event_id;
    logic            event_press;

    modport master (
        output event_valid,
        output event_id,
        output event_press,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_id,
        input  event_press,
        output event_ready
    );
endinterface

// File: rtl/button_event_fifo.sv
// Small synchronous FIFO of button events with a registered head entry.
// Total occupancy (storage plus head) is capped at DEPTH; a push that finds
// the FIFO full is dropped unless the head is popped on the same edge.
// A push into an empty FIFO shows up on out_valid one cycle later, because
// the head register is refilled from storage only after the write lands.
module button_event_fifo
    import button_scanner_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid,
    input  button_event_t push_data,
    input  logic          pop_ready,
    output logic          out_valid,
    output button_event_t out_data,
    output logic          full,
    output logic          overflow
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    button_event_t    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0] total_cnt;
    button_event_t    head_q, head_d;
    logic             head_valid_q, head_valid_d;
    logic             overflow_q, overflow_d;
    logic             pop;
    logic             push_ok;
    logic             load;

    // Handshake decode, head refill and pointer/count bookkeeping.
    always_comb begin
        pop          = head_valid_q && pop_ready;
        total_cnt    = mem_cnt_q + CNT_W'(head_valid_q);
        full         = (total_cnt == CNT_W'(DEPTH));
        push_ok      = push_valid && (!full || pop);
        load         = (!head_valid_q || pop) && (mem_cnt_q != '0);
        wr_ptr_d     = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d     = rd_ptr_q + PTR_W'(load);
        mem_cnt_d    = mem_cnt_q + CNT_W'(push_ok) - CNT_W'(load);
        head_d       = head_q;
        head_valid_d = head_valid_q;
        if (load) begin
            head_d       = mem_q[rd_ptr_q];
            head_valid_d = 1'b1;
        end else if (pop) begin
            head_valid_d = 1'b0;
        end
        overflow_d   = overflow_q || (push_valid && !push_ok);
    end

    // Event storage; contents need no reset since the pointers guard them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers, head register and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_cnt_q    <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_cnt_q    <= mem_cnt_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_valid = head_valid_q;
    assign out_data  = head_q;
    assign overflow  = overflow_q;

endmodule

// File: rtl/button_scanner.sv
// Time-multiplexed button debouncer: a prescaler tick starts a scan that
// walks every channel, one per clock, through a single shift/compare unit.
// Debounced level changes are queued as press/release events.
// Optional macro BUTTON_SCANNER_SYNC_EN inserts a 2-flop input synchronizer.
module button_scanner
    import button_scanner_pkg::*;
#(
    parameter int N_BUTTONS = 4,
    parameter int HIST_LEN  = 8,
    parameter int TICK_DIV  = 1000,
    parameter int EVT_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] buttons,
    output logic [N_BUTTONS-1:0] debounced,
    button_scanner_if.master     evt,
    output logic                 overflow
);

    localparam int IDX_W = clog2_min1(N_BUTTONS);
    localparam int CNT_W = clog2_min1(TICK_DIV);

    logic [N_BUTTONS-1:0] sample;

`ifdef BUTTON_SCANNER_SYNC_EN
    logic [N_BUTTONS-1:0] sync1_q, sync1_d;
    logic [N_BUTTONS-1:0] sync2_q, sync2_d;

    // Two-stage synchronizer feeding the sampler.
    always_comb begin
        sync1_d = buttons;
        sync2_d = sync1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sample = sync2_q;
`else
    // Pads deliver already-synchronous levels.
    assign sample = buttons;
`endif

    // ---------------- prescaler ----------------
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick;

    // Free-running 0..TICK_DIV-1 counter; tick marks the last count.
    always_comb begin
        tick    = (count_q == CNT_W'(TICK_DIV - 1));
        count_d = tick ? '0 : count_q + CNT_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // ---------------- scan sequencer ----------------
    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             scan_active;

    // Next-state logic: a tick launches a scan; the last channel ends it.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        scan_active = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                scan_active = 1'b1;
                if (idx_q == IDX_W'(N_BUTTONS - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ---------------- shared history/compare unit ----------------
    logic [HIST_LEN-1:0]  hist_q [N_BUTTONS];
    logic [HIST_LEN-1:0]  hist_d [N_BUTTONS];
    logic [N_BUTTONS-1:0] debounced_q, debounced_d;
    logic [HIST_LEN-1:0]  cur_hist;
    logic [HIST_LEN-1:0]  shifted_hist;
    logic                 cur_level;
    logic                 new_level;
    logic                 level_change;

    // Shift the current channel's sample in and decide its new level.
    always_comb begin
        cur_hist     = hist_q[idx_q];
        shifted_hist = {cur_hist[HIST_LEN-2:0], sample[idx_q]};
        cur_level    = debounced_q[idx_q];
        new_level    = cur_level;
        if (&shifted_hist) begin
            new_level = 1'b1;
        end else if (shifted_hist == '0) begin
            new_level = 1'b0;
        end
        level_change = scan_active && (new_level != cur_level);
    end

    // Write back only the channel being scanned.
    always_comb begin
        hist_d      = hist_q;
        debounced_d = debounced_q;
        if (scan_active) begin
            hist_d[idx_q]      = shifted_hist;
            debounced_d[idx_q] = new_level;
        end
    end

    // History array and debounced levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                hist_q[i] <= '0;
            end
            debounced_q <= '0;
        end else begin
            hist_q      <= hist_d;
            debounced_q <= debounced_d;
        end
    end

    assign debounced = debounced_q;

    // ---------------- event queue ----------------
    button_event_t push_data;
    button_event_t head_data;
    logic          head_valid;
    logic          fifo_full;
    logic          unused_bits;

    // Event record for the channel whose level just changed.
    always_comb begin
        push_data                 = '0;
        push_data.id[IDX_W-1:0]   = idx_q;
        push_data.press           = new_level;
    end

    button_event_fifo #(
        .DEPTH (EVT_DEPTH)
    ) u_event_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (level_change),
        .push_data  (push_data),
        .pop_ready  (evt.event_ready),
        .out_valid  (head_valid),
        .out_data   (head_data),
        .full       (fifo_full),
        .overflow   (overflow)
    );

    assign evt.event_valid = head_valid;
    assign evt.event_id    = head_data.id[IDX_W-1:0];
    assign evt.event_press = head_data.press;

    // Upper id bits exist only for wider configurations.
    assign unused_bits = &{1'b0, head_data.id, fifo_full};

endmodule

// File: tb/tb_button_scanner.sv
// Directed bench for button_scanner (N=4, HIST_LEN=4, TICK_DIV=8, DEPTH=4).
// Cycle numbering: cycle 1 is the first cycle after reset release; ticks
// fall on cycles 8, 16, 24, ... and channel i of tick T settles in T+2+i.
module tb_button_scanner;
    import button_scanner_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] buttons = 4'hF;
    logic [3:0] debounced;
    logic       overflow;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    button_scanner_if #(.ID_W(2)) evt_if ();

    button_scanner #(
        .N_BUTTONS (4),
        .HIST_LEN  (4),
        .TICK_DIV  (8),
        .EVT_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .buttons   (buttons),
        .debounced (debounced),
        .evt       (evt_if),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad_deb;
        int ev_cnt;
        logic [1:0] exp_id [4];
        logic       exp_pr [4];

        evt_if.event_ready = 1'b0;

        // ---- reset state and first tick ----
        do_reset(3);
        $display("reset: deb=%h valid=%b ovf=%b", debounced, evt_if.event_valid, overflow);
        chk("rst_debounced", 32'(debounced), 32'h0);
        chk("rst_valid", 32'(evt_if.event_valid), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        buttons = 4'b0100;
        goto(7);
        chk("tick_c7", 32'(dut.tick), 32'h0);
        goto(8);
        chk("tick_c8", 32'(dut.tick), 32'h1);
        goto(9);
        chk("scan_c9", 32'(dut.state_q), 32'(SCAN));

        // ---- channel 2 debounce timing ----
        goto(35);
        chk("deb2_c35", 32'(debounced), 32'h0);
        goto(36);
        $display("ch2: cycle=%0d deb=%h valid=%b", cyc, debounced, evt_if.event_valid);
        chk("deb2_c36", 32'(debounced), 32'h4);
        chk("valid_c36", 32'(evt_if.event_valid), 32'h0);
        goto(37);
        $display("ch2 event: valid=%b id=%0d press=%b", evt_if.event_valid, evt_if.event_id, evt_if.event_press);
        chk("valid_c37", 32'(evt_if.event_valid), 32'h1);
        chk("id_c37", 32'(evt_if.event_id), 32'h2);
        chk("press_c37", 32'(evt_if.event_press), 32'h1);
        evt_if.event_ready = 1'b1;
        step();
        chk("valid_after_pop", 32'(evt_if.event_valid), 32'h0);

        // ---- bouncing channel 0 never settles ----
        bad_deb = 0;
        ev_cnt = 0;
        for (int k = 0; k < 96; k++) begin
            if (cyc % 8 == 2) buttons[0] = ~buttons[0];
            if (debounced[0] !== 1'b0) bad_deb++;
            if (evt_if.event_valid === 1'b1) ev_cnt++;
            step();
        end
        $display("bounce: bad_deb=%0d events=%0d", bad_deb, ev_cnt);
        chk("bounce_deb0", 32'(bad_deb), 32'h0);
        chk("bounce_events", 32'(ev_cnt), 32'h0);
        chk("bounce_deb", 32'(debounced), 32'h4);
        buttons[0] = 1'b0;

        // ---- fill, overflow, drain ----
        evt_if.event_ready = 1'b0;
        do_reset(2);
        buttons = 4'hF;
        goto(34);
        chk("fill_deb_c34", 32'(debounced), 32'h1);
        goto(35);
        chk("fill_valid_c35", 32'(evt_if.event_valid), 32'h1);
        goto(38);
        chk("fill_deb_c38", 32'(debounced), 32'hF);
        chk("fill_id_c38", 32'(evt_if.event_id), 32'h0);
        buttons = 4'b1110;
        goto(65);
        chk("ovf_c65", 32'(overflow), 32'h0);
        goto(66);
        $display("overflow: cycle=%0d ovf=%b deb=%h", cyc, overflow, debounced);
        chk("ovf_c66", 32'(overflow), 32'h1);
        chk("ovf_deb_c66", 32'(debounced), 32'hE);
        chk("ovf_head_id", 32'(evt_if.event_id), 32'h0);
        evt_if.event_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            $display("drain %0d: valid=%b id=%0d press=%b", i, evt_if.event_valid, evt_if.event_id, evt_if.event_press);
            chk("drain_valid", 32'(evt_if.event_valid), 32'h1);
            chk("drain_id", 32'(evt_if.event_id), 32'(i));
            chk("drain_press", 32'(evt_if.event_press), 32'h1);
            step();
        end
        chk("drain_empty", 32'(evt_if.event_valid), 32'h0);
        chk("drain_ovf_sticky", 32'(overflow), 32'h1);

        // ---- push and pop together on a full FIFO ----
        evt_if.event_ready = 1'b0;
        do_reset(2);
        buttons = 4'hF;
        goto(38);
        buttons = 4'b1110;
        chk("full_head_c38", 32'(evt_if.event_id), 32'h0);
        goto(65);
        evt_if.event_ready = 1'b1;
        chk("full_valid_c65", 32'(evt_if.event_valid), 32'h1);
        chk("full_id_c65", 32'(evt_if.event_id), 32'h0);
        step();
        chk("full_ovf_c66", 32'(overflow), 32'h0);
        chk("full_deb_c66", 32'(debounced), 32'hE);
        exp_id[0] = 2'd1; exp_pr[0] = 1'b1;
        exp_id[1] = 2'd2; exp_pr[1] = 1'b1;
        exp_id[2] = 2'd3; exp_pr[2] = 1'b1;
        exp_id[3] = 2'd0; exp_pr[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            $display("full drain %0d: valid=%b id=%0d press=%b", i, evt_if.event_valid, evt_if.event_id, evt_if.event_press);
            chk("fdrain_valid", 32'(evt_if.event_valid), 32'h1);
            chk("fdrain_id", 32'(evt_if.event_id), 32'(exp_id[i]));
            chk("fdrain_press", 32'(evt_if.event_press), 32'(exp_pr[i]));
            step();
        end
        chk("fdrain_empty", 32'(evt_if.event_valid), 32'h0);
        chk("fdrain_ovf", 32'(overflow), 32'h0);

        // ---- reset in the middle of a scan ----
        evt_if.event_ready = 1'b0;
        do_reset(2);
        buttons = 4'hF;
        goto(41);
        chk("mid_valid_c41", 32'(evt_if.event_valid), 32'h1);
        chk("mid_idx_c41", 32'(dut.idx_q), 32'h0);
        step();
        chk("mid_state_c42", 32'(dut.state_q), 32'(SCAN));
        chk("mid_idx_c42", 32'(dut.idx_q), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 1;
        $display("mid reset: state=%0d valid=%b deb=%h", dut.state_q, evt_if.event_valid, debounced);
        chk("mid_state", 32'(dut.state_q), 32'(IDLE));
        chk("mid_valid", 32'(evt_if.event_valid), 32'h0);
        chk("mid_deb", 32'(debounced), 32'h0);
        chk("mid_ovf", 32'(overflow), 32'h0);
        goto(7);
        chk("mid_tick_c7", 32'(dut.tick), 32'h0);
        goto(8);
        chk("mid_tick_c8", 32'(dut.tick), 32'h1);
        chk("mid_deb_c8", 32'(debounced), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
